mul_arbiter: RTL
================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter TAG_W, default 4, SHALL set the requester tag width.
REQ-002 Parameter TIMEOUT, default 63, SHALL set the maximum number of RUN cycles to wait for mul_complete.
REQ-003 mul_clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-004 reset  in  1  reset is synchronous and active-high.
REQ-005 req_valid  in  2  per-port request valid (port 0 = bit 0).
REQ-006 req_ready  out  2  per-port request accept.
REQ-007 req_signed  in  2  per-port signed-multiply flag.
REQ-008 req_x, req_y  in  2x32 each  per-port operands.
REQ-009 req_tag  in  2xTAG_W  per-port transaction tag.
REQ-010 rsp_valid  out  1  response valid.
REQ-011 rsp_ready  in  1  response accept from the consumer.
REQ-012 rsp_port  out  1  index of the port that issued the response.
REQ-013 rsp_tag  out  TAG_W  tag of the request that produced the response.
REQ-014 rsp_result  out  64  product.
REQ-015 rsp_err  out  1  timeout flag.
REQ-016 mul_run, mul_signed  out  1 each  multiplier control.
REQ-017 mul_x, mul_y  out  32 each  multiplier operands.
REQ-018 mul_result  in  64  multiplier product.
REQ-019 mul_complete  in  1  multiplier done.

Function
REQ-020 The FSM SHALL have three states, IDLE, RUN and RESP; it resets to IDLE.
REQ-021 IDLE: req_ready SHALL be one-hot on the granted port when any req_valid is high, and SHALL be 0 otherwise; it is combinational from req_valid and the grant pointer.
REQ-022 Arbitration SHALL be round-robin:
- a single valid port wins;
- if both are valid, the port not granted last wins;
- after reset, port 0 has priority.
REQ-023 On acceptance (req_valid & req_ready), the controller SHALL:
- latch signed, x, y, tag and port index;
- update the grant pointer;
- enter RUN on the next edge.
REQ-024 RUN: mul_run SHALL be 1, and mul_signed, mul_x and mul_y SHALL hold the latched values constant for the whole state.
REQ-025 mul_run, mul_signed, mul_x and mul_y SHALL be registered outputs, and SHALL be 0 in IDLE and in RESP.
REQ-026 RUN, mul_complete sampled high: the controller SHALL capture mul_result into rsp_result, clear rsp_err and enter RESP on the same edge.
REQ-027 RUN cycle counter:
- it SHALL clear on RUN entry and increment each RUN cycle;
- if it reaches TIMEOUT with mul_complete low, the controller SHALL enter RESP with rsp_err=1 and rsp_result=0.
REQ-028 RESP: rsp_valid SHALL be 1, and rsp_port, rsp_tag, rsp_result and rsp_err SHALL be stable until rsp_valid & rsp_ready.
REQ-029 RESP, rsp_valid & rsp_ready: the controller SHALL return to IDLE, and rsp_valid SHALL be 0 in the following cycle.
REQ-030 mul_run SHALL be low for at least one full cycle between consecutive operations, so the multiplier clears complete and its counter; RESP guarantees this.
REQ-031 req_ready SHALL be 0 in RUN and RESP; a new request is never accepted in the same cycle a response is consumed.
REQ-032 A requester dropping req_valid before acceptance SHALL NOT corrupt state; arbitration is re-evaluated every IDLE cycle.
REQ-033 mul_complete seen in IDLE or RESP SHALL be ignored.
REQ-034 Throughput SHALL be one operation in flight; minimum issue interval = RUN length + 2 cycles.

Reset
REQ-035 Reset high at any edge, including mid-RUN or mid-RESP, SHALL force:
- state IDLE;
- grant pointer to port 0;
- req_ready=0, rsp_valid=0, rsp_err=0;
- rsp_port=0, rsp_tag=0, rsp_result=0;
- mul_run=0, mul_signed=0, mul_x=0, mul_y=0;
- RUN counter=0.
REQ-036 An in-flight operation SHALL be dropped with no response.

Verification
REQ-037 Single op: port 0 unsigned x=3, y=5, tag=2, multiplier model completes after 34 RUN cycles -> mul_run rises the cycle after acceptance; rsp_valid=1 with rsp_port=0, tag=2, result=15, err=0.
REQ-038 Signed op: port 1 x=32'hFFFF_FFFE (-2), y=7, signed -> rsp_result=64'hFFFF_FFFF_FFFF_FFF2, rsp_port=1.
REQ-039 Contention: both ports valid continuously from reset -> grants alternate 0,1,0,1; each response carries the matching tag; mul_run is low for at least 1 cycle between ops.
REQ-040 Backpressure: rsp_ready held 0 for 10 cycles in RESP -> outputs stable, no new req_ready; releasing rsp_ready -> IDLE next cycle.
REQ-041 Timeout: mul_complete tied 0 -> after TIMEOUT RUN cycles rsp_valid=1, rsp_err=1, rsp_result=0.
REQ-042 Reset mid-RUN (cycle 10) -> next cycle mul_run=0, rsp_valid=0, no response issued; a new port-1 request then receives priority behaviour as from reset.

Source files
------------

// File: rtl/mul_arbiter.sv
// Two-port round-robin front end for a shared iterative multiplier.
// One operation in flight: IDLE accepts, RUN drives the multiplier, RESP holds the result.
module mul_arbiter #(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 63
) (
    input  logic                  mul_clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_signed,
    input  logic [1:0][31:0]      req_x,
    input  logic [1:0][31:0]      req_y,
    input  logic [1:0][TAG_W-1:0] req_tag,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_port,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic [63:0]           rsp_result,
    output logic                  rsp_err,
    output logic                  mul_run,
    output logic                  mul_signed,
    output logic [31:0]           mul_x,
    output logic [31:0]           mul_y,
    input  logic [63:0]           mul_result,
    input  logic                  mul_complete
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic             prio_q;
    logic [CNT_W-1:0] cnt_q;
    logic             op_port_q;
    logic [TAG_W-1:0] op_tag_q;

    logic             mul_run_q;
    logic             mul_signed_q;
    logic [31:0]      mul_x_q;
    logic [31:0]      mul_y_q;

    logic             rsp_valid_q;
    logic             rsp_port_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic [63:0]      rsp_result_q;
    logic             rsp_err_q;

    logic             grant_d;
    logic             timeout_d;

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        grant_d   = 1'b0;
        req_ready = 2'b00;
        if (req_valid == 2'b11) begin
            grant_d = prio_q;
        end else begin
            grant_d = req_valid[1];
        end
        if (state_q == S_IDLE && !reset && req_valid != 2'b00) begin
            req_ready = grant_d ? 2'b10 : 2'b01;
        end
    end

    assign timeout_d = (cnt_q == CNT_W'(TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge mul_clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            prio_q       <= 1'b0;
            cnt_q        <= '0;
            op_port_q    <= 1'b0;
            op_tag_q     <= '0;
            mul_run_q    <= 1'b0;
            mul_signed_q <= 1'b0;
            mul_x_q      <= '0;
            mul_y_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_port_q   <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid != 2'b00) begin
                        op_port_q    <= grant_d;
                        op_tag_q     <= req_tag[grant_d];
                        mul_signed_q <= req_signed[grant_d];
                        mul_x_q      <= req_x[grant_d];
                        mul_y_q      <= req_y[grant_d];
                        mul_run_q    <= 1'b1;
                        prio_q       <= ~grant_d;
                        cnt_q        <= '0;
                        state_q      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (mul_complete || timeout_d) begin
                        // Completion wins over a coincident timeout.
                        rsp_result_q <= mul_complete ? mul_result : 64'd0;
                        rsp_err_q    <= ~mul_complete;
                        rsp_port_q   <= op_port_q;
                        rsp_tag_q    <= op_tag_q;
                        rsp_valid_q  <= 1'b1;
                        mul_run_q    <= 1'b0;
                        mul_signed_q <= 1'b0;
                        mul_x_q      <= '0;
                        mul_y_q      <= '0;
                        state_q      <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mul_run    = mul_run_q;
    assign mul_signed = mul_signed_q;
    assign mul_x      = mul_x_q;
    assign mul_y      = mul_y_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_port   = rsp_port_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;

    a_ready_onehot: assert property (@(posedge mul_clk) disable iff (reset)
        $onehot0(req_ready));
    a_run_in_run: assert property (@(posedge mul_clk) disable iff (reset)
        mul_run_q |-> state_q == S_RUN);
    a_rsp_in_resp: assert property (@(posedge mul_clk) disable iff (reset)
        rsp_valid_q |-> state_q == S_RESP);

endmodule
